// File: rtl/pc_sequencer.sv
// ============================================================================
// pc_sequencer : program counter and next-fetch-address selection
// Rev 1.0
// ============================================================================
`default_nettype none

module pc_sequencer #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter logic [31:0] EXC_VECTOR = 32'h8000_0180
) (
   input  logic        Clk,
   input  logic        Rst,
   input  logic        stall,
   input  logic        br_taken,
   input  logic [31:0] br_pc4,
   input  logic [15:0] br_imm,
   input  logic        jr,
   input  logic [31:0] jr_addr,
   input  logic        jmp,
   input  logic [31:0] jmp_pc4,
   input  logic [25:0] jmp_addr,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic        flush,
   output logic        misalign_exc,
   output logic [31:0] epc,
   output logic        redirect_pend
);

   typedef enum logic [0:0] {RUN = 1'b0, HOLD = 1'b1} state_t;

   state_t      state, state_next;
   logic [31:0] pend, pend_next;
   logic [31:0] pc_next, epc_next;
   logic        flush_next, exc_next;

   logic [31:0] br_tgt, jmp_tgt, tgt;
   logic        redirect;
   logic        load;
   logic [31:0] load_tgt;

   assign br_tgt   = br_pc4 + {{14{br_imm[15]}}, br_imm, 2'b00};
   assign jmp_tgt  = {jmp_pc4[31:28], jmp_addr, 2'b00};
   assign redirect = br_taken | jr | jmp;
   // Older pipeline stage wins when several redirects collide
   assign tgt      = br_taken ? br_tgt : (jr ? jr_addr : jmp_tgt);

   assign pc_plus4      = pc + 32'd4;
   assign redirect_pend = (state == HOLD);

   always_comb begin
      state_next = state;
      pend_next  = pend;
      pc_next    = pc;
      epc_next   = epc;
      flush_next = 1'b0;
      exc_next   = 1'b0;
      load       = 1'b0;
      load_tgt   = tgt;

      case (state)
         RUN: begin
            if (!stall) begin
               if (redirect) load = 1'b1;
               else          pc_next = pc_plus4;
            end else if (redirect) begin
               pend_next  = tgt;
               state_next = HOLD;
            end
         end
         HOLD: begin
            // Redirect inputs are ignored here: the stalled stage re-presents them
            if (!stall) begin
               load       = 1'b1;
               load_tgt   = pend;
               state_next = RUN;
            end
         end
         default: state_next = RUN;
      endcase

      if (load) begin
         flush_next = 1'b1;
         if (load_tgt[1:0] != 2'b00) begin
            pc_next  = EXC_VECTOR;
            epc_next = load_tgt;
            exc_next = 1'b1;
         end else begin
            pc_next = load_tgt;
         end
      end
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state        <= RUN;
         pend         <= 32'd0;
         pc           <= RESET_PC;
         epc          <= 32'd0;
         flush        <= 1'b0;
         misalign_exc <= 1'b0;
      end else begin
         state        <= state_next;
         pend         <= pend_next;
         pc           <= pc_next;
         epc          <= epc_next;
         flush        <= flush_next;
         misalign_exc <= exc_next;
      end
   end

endmodule

`default_nettype wire
